// File: rtl/triangle_ctrl_pkg.sv
// Shared definitions for the triangle vertex controller: coordinate width,
// default raster geometry, reset triangle and FSM state encoding.
package triangle_ctrl_pkg;

   localparam int unsigned COORD_W         = 10;
   localparam int unsigned V_ACTIVE_DEF    = 480;
   localparam int unsigned XMAX_DEF        = 639;
   localparam int unsigned STEP_FRAMES_DEF = 2;

   typedef logic [COORD_W-1:0] coord_t;

   // Full vertex set as handed to the rasterizer.
   typedef struct packed {
      coord_t ax;
      coord_t ay;
      coord_t bx;
      coord_t by;
      coord_t cx;
      coord_t cy;
   } tri_t;

   localparam tri_t TRI_RESET = '{
      ax: COORD_W'(320), ay: COORD_W'(60),
      bx: COORD_W'(112), by: COORD_W'(420),
      cx: COORD_W'(528), cy: COORD_W'(420)
   };

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_COMMIT = 2'd1,
      ST_BLANK  = 2'd2
   } state_e;

endpackage

// File: rtl/triangle_ctrl_vertex_bounce.sv
// One horizontal bounce step of the triangle's x coordinates.
// Ports: ax_i/bx_i/cx_i current x, dir_neg_i current direction (1 = moving left);
//        ax_o/bx_o/cx_o stepped x, dir_neg_o direction after the step.
module triangle_ctrl_vertex_bounce
   import triangle_ctrl_pkg::*;
#(
   parameter int unsigned XMAX = XMAX_DEF
) (
   input  logic [COORD_W-1:0] ax_i,
   input  logic [COORD_W-1:0] bx_i,
   input  logic [COORD_W-1:0] cx_i,
   input  logic               dir_neg_i,
   output logic [COORD_W-1:0] ax_o,
   output logic [COORD_W-1:0] bx_o,
   output logic [COORD_W-1:0] cx_o,
   output logic               dir_neg_o
);

   coord_t max_c;
   coord_t min_c;

   // Extent of the triangle decides when to reverse; the step uses the new direction.
   always_comb begin
      max_c = (ax_i > bx_i) ? ax_i : bx_i;
      max_c = (max_c > cx_i) ? max_c : cx_i;
      min_c = (ax_i < bx_i) ? ax_i : bx_i;
      min_c = (min_c < cx_i) ? min_c : cx_i;

      dir_neg_o = dir_neg_i;
      if (!dir_neg_i && (max_c >= COORD_W'(XMAX))) begin
         dir_neg_o = 1'b1;
      end else if (dir_neg_i && (min_c == '0)) begin
         dir_neg_o = 1'b0;
      end

      if (dir_neg_o) begin
         ax_o = ax_i - COORD_W'(1);
         bx_o = bx_i - COORD_W'(1);
         cx_o = cx_i - COORD_W'(1);
      end else begin
         ax_o = ax_i + COORD_W'(1);
         bx_o = bx_i + COORD_W'(1);
         cx_o = cx_i + COORD_W'(1);
      end
   end

endmodule

// File: rtl/triangle_ctrl.sv
// Frame-synchronous vertex controller: buffers one triangle command and commits
// it (or a bounce-animation step) at the first blanking line, so vertices are
// stable across the active region.
// Ports: clk_pix/resetn clock and async active-low reset; x/y scan position;
//        anim_en bounce enable; cmd_valid/cmd_ready + cmd_* command handshake;
//        ax..cy registered vertices; pending command buffered; commit update pulse.
module triangle_ctrl
   import triangle_ctrl_pkg::*;
#(
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned XMAX        = XMAX_DEF,
   parameter int unsigned STEP_FRAMES = STEP_FRAMES_DEF
) (
   input  logic               clk_pix,
   input  logic               resetn,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               anim_en,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COORD_W-1:0] cmd_ax,
   input  logic [COORD_W-1:0] cmd_ay,
   input  logic [COORD_W-1:0] cmd_bx,
   input  logic [COORD_W-1:0] cmd_by,
   input  logic [COORD_W-1:0] cmd_cx,
   input  logic [COORD_W-1:0] cmd_cy,
   output logic [COORD_W-1:0] ax,
   output logic [COORD_W-1:0] ay,
   output logic [COORD_W-1:0] bx,
   output logic [COORD_W-1:0] by,
   output logic [COORD_W-1:0] cx,
   output logic [COORD_W-1:0] cy,
   output logic               pending,
   output logic               commit
);

   localparam int unsigned CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

   state_e           state_q, state_d;
   tri_t             vtx_q, vtx_d;
   tri_t             buf_q, buf_d;
   tri_t             cmd_c;
   logic             pend_q, pend_d;
   logic             ready_q, ready_d;
   logic             dir_neg_q, dir_neg_d;
   logic             commit_q, commit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fire_c;
   logic             at_origin_c;
   coord_t           ax_nx, bx_nx, cx_nx;
   logic             dir_neg_nx;

   assign cmd_c = '{ax: cmd_ax, ay: cmd_ay, bx: cmd_bx, by: cmd_by, cx: cmd_cx, cy: cmd_cy};

   assign at_origin_c = (x == '0) && (y == '0);
   assign fire_c      = (state_q == ST_ACTIVE) && (x == '0) && (y == COORD_W'(V_ACTIVE));

   triangle_ctrl_vertex_bounce #(
      .XMAX (XMAX)
   ) u_bounce (
      .ax_i      (vtx_q.ax),
      .bx_i      (vtx_q.bx),
      .cx_i      (vtx_q.cx),
      .dir_neg_i (dir_neg_q),
      .ax_o      (ax_nx),
      .bx_o      (bx_nx),
      .cx_o      (cx_nx),
      .dir_neg_o (dir_neg_nx)
   );

   // Next state: frame sequencing, commit actions and command capture.
   always_comb begin
      state_d   = state_q;
      vtx_d     = vtx_q;
      buf_d     = buf_q;
      pend_d    = pend_q;
      dir_neg_d = dir_neg_q;
      cnt_d     = cnt_q;
      commit_d  = 1'b0;

      case (state_q)
         ST_ACTIVE: if (fire_c) state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_BLANK;
         ST_BLANK:  if (at_origin_c) state_d = ST_ACTIVE;
         default:   state_d = ST_ACTIVE;
      endcase

      // Vertices change on the edge entering COMMIT, so commit_q and the new
      // values appear together; a buffered command pre-empts animation.
      if (fire_c) begin
         commit_d = 1'b1;
         if (pend_q) begin
            vtx_d     = buf_q;
            pend_d    = 1'b0;
            dir_neg_d = 1'b0;
            cnt_d     = '0;
         end else if (anim_en) begin
            if (cnt_q == CNT_W'(STEP_FRAMES - 1)) begin
               cnt_d     = '0;
               vtx_d.ax  = ax_nx;
               vtx_d.bx  = bx_nx;
               vtx_d.cx  = cx_nx;
               dir_neg_d = dir_neg_nx;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      // Capture only when empty; pending_q gates both this and the commit load.
      if (cmd_valid && !pend_q) begin
         buf_d  = cmd_c;
         pend_d = 1'b1;
      end

      ready_d = !pend_d;
   end

   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_ACTIVE;
         vtx_q     <= TRI_RESET;
         buf_q     <= '0;
         pend_q    <= 1'b0;
         ready_q   <= 1'b1;
         dir_neg_q <= 1'b0;
         cnt_q     <= '0;
         commit_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         vtx_q     <= vtx_d;
         buf_q     <= buf_d;
         pend_q    <= pend_d;
         ready_q   <= ready_d;
         dir_neg_q <= dir_neg_d;
         cnt_q     <= cnt_d;
         commit_q  <= commit_d;
      end
   end

   assign ax        = vtx_q.ax;
   assign ay        = vtx_q.ay;
   assign bx        = vtx_q.bx;
   assign by        = vtx_q.by;
   assign cx        = vtx_q.cx;
   assign cy        = vtx_q.cy;
   assign pending   = pend_q;
   assign cmd_ready = ready_q;
   assign commit    = commit_q;

endmodule

// File: tb/tb_triangle_ctrl.sv
// Bench for triangle_ctrl on a compressed raster (4 columns x 12 lines,
// first blanking line 8) against a frame-level reference model.
module tb_triangle_ctrl;

   localparam int H  = 4;
   localparam int VT = 12;
   localparam int VA = 8;
   localparam int XM = 639;
   localparam int SF = 2;

   logic       clk_pix = 1'b0;
   logic       resetn  = 1'b0;
   logic [9:0] x = '0, y = '0;
   logic       anim_en = 1'b0, cmd_valid = 1'b0;
   logic [9:0] cmd_ax = '0, cmd_ay = '0, cmd_bx = '0, cmd_by = '0, cmd_cx = '0, cmd_cy = '0;
   logic       cmd_ready, pending, commit;
   logic [9:0] ax, ay, bx, by, cx, cy;
   logic [59:0] dvec;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_x[3], m_y[3], b_x[3], b_y[3];
   int m_dir, m_cnt;
   bit m_pend, armed, m_commit;
   int rx = 0, ry = 0, px = 0, py = 0;

   localparam logic [59:0] DEF_VEC = {10'd320, 10'd60, 10'd112, 10'd420, 10'd528, 10'd420};

   triangle_ctrl #(.V_ACTIVE(VA), .XMAX(XM), .STEP_FRAMES(SF)) dut (
      .clk_pix(clk_pix), .resetn(resetn), .x(x), .y(y), .anim_en(anim_en),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ax(cmd_ax), .cmd_ay(cmd_ay), .cmd_bx(cmd_bx),
      .cmd_by(cmd_by), .cmd_cx(cmd_cx), .cmd_cy(cmd_cy),
      .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
      .pending(pending), .commit(commit)
   );

   assign dvec = {ax, ay, bx, by, cx, cy};

   always #5 clk_pix = ~clk_pix;

   function automatic logic [59:0] mvec();
      return {10'(m_x[0]), 10'(m_y[0]), 10'(m_x[1]), 10'(m_y[1]), 10'(m_x[2]), 10'(m_y[2])};
   endfunction

   task automatic model_reset();
      m_x = '{320, 112, 528};
      m_y = '{60, 420, 420};
      m_dir = 1; m_cnt = 0; m_pend = 0; armed = 1; m_commit = 0;
   endtask

   // One pixel clock: update the model from the inputs presented, clock, move the raster.
   task automatic advance();
      bit pb;
      int mx, mn;
      pb = m_pend;
      m_commit = 0;
      if (armed && rx == 0 && ry == VA) begin
         m_commit = 1;
         armed = 0;
         if (m_pend) begin
            m_x = b_x; m_y = b_y; m_pend = 0; m_dir = 1; m_cnt = 0;
         end else if (anim_en) begin
            if (m_cnt == SF - 1) begin
               m_cnt = 0;
               mx = m_x[0]; mn = m_x[0];
               for (int i = 1; i < 3; i++) begin
                  if (m_x[i] > mx) mx = m_x[i];
                  if (m_x[i] < mn) mn = m_x[i];
               end
               if (m_dir == 1 && mx >= XM) m_dir = -1;
               else if (m_dir == -1 && mn == 0) m_dir = 1;
               for (int i = 0; i < 3; i++) m_x[i] = (m_x[i] + m_dir) & 1023;
            end else begin
               m_cnt++;
            end
         end
      end else if (!armed && rx == 0 && ry == 0) begin
         armed = 1;
      end
      if (cmd_valid && !pb) begin
         b_x = '{int'(cmd_ax), int'(cmd_bx), int'(cmd_cx)};
         b_y = '{int'(cmd_ay), int'(cmd_by), int'(cmd_cy)};
         m_pend = 1;
      end
      px = rx; py = ry;
      @(posedge clk_pix); #1;
      rx++;
      if (rx == H) begin
         rx = 0; ry++;
         if (ry == VT) ry = 0;
      end
      x = 10'(rx); y = 10'(ry);
   endtask

   task automatic hw_reset();
      resetn = 1'b0; cmd_valid = 1'b0;
      rx = 0; ry = 0; x = '0; y = '0;
      model_reset();
      repeat (2) @(posedge clk_pix);
      #1 resetn = 1'b1;
   endtask

   task automatic run_to_commit();
      int n;
      n = 0;
      do begin
         advance();
         n++;
      end while (commit !== 1'b1 && n < 200);
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL commit_timeout got=no_commit exp=commit within 200 cycles");
      end
   endtask

   task automatic send_cmd(input int a0, a1, b0, b1, c0, c1);
      cmd_valid = 1'b1;
      cmd_ax = 10'(a0); cmd_ay = 10'(a1); cmd_bx = 10'(b0);
      cmd_by = 10'(b1); cmd_cx = 10'(c0); cmd_cy = 10'(c1);
      advance();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      hw_reset();
      total++; if (dvec !== DEF_VEC) begin bad++; $display("FAIL reset_vtx got=%h exp=%h", dvec, DEF_VEC); end
      total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", pending); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      total++; if (commit !== 1'b0) begin bad++; $display("FAIL reset_commit got=%b exp=0", commit); end
   endtask

   task automatic test_idle_frames();
      int ncommit;
      ncommit = 0;
      anim_en = 1'b0;
      for (int i = 0; i < 3 * H * VT; i++) begin
         advance();
         total++;
         if (commit !== m_commit) begin bad++; $display("FAIL idle_commit cyc=%0d got=%b exp=%b", i, commit, m_commit); end
         if (commit === 1'b1) begin
            ncommit++;
            total++;
            if (px != 0 || py != VA) begin bad++; $display("FAIL idle_commit_pos got=(%0d,%0d) exp=(0,%0d)", px, py, VA); end
         end
      end
      total++; if (ncommit != 3) begin bad++; $display("FAIL idle_commit_count got=%0d exp=3", ncommit); end
      total++; if (dvec !== DEF_VEC) begin bad++; $display("FAIL idle_vtx got=%h exp=%h", dvec, DEF_VEC); end
   endtask

   task automatic test_command();
      logic [59:0] exp_v;
      exp_v = {10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd60};
      repeat (6) advance();
      send_cmd(10, 20, 30, 40, 50, 60);
      total++; if (pending !== 1'b1) begin bad++; $display("FAIL cmd_pending got=%b exp=1", pending); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL cmd_ready_low got=%b exp=0", cmd_ready); end
      // A second offer while full must be ignored.
      cmd_valid = 1'b1;
      cmd_ax = 10'd999; cmd_ay = 10'd999; cmd_bx = 10'd999;
      cmd_by = 10'd999; cmd_cx = 10'd999; cmd_cy = 10'd999;
      repeat (3) advance();
      cmd_valid = 1'b0;
      total++; if (dvec !== DEF_VEC) begin bad++; $display("FAIL cmd_hold got=%h exp=%h", dvec, DEF_VEC); end
      run_to_commit();
      total++; if (m_commit !== 1'b1) begin bad++; $display("FAIL cmd_commit_time got=dut_commit exp=no_commit"); end
      total++; if (dvec !== exp_v) begin bad++; $display("FAIL cmd_applied got=%h exp=%h", dvec, exp_v); end
      total++; if (pending !== 1'b0) begin bad++; $display("FAIL cmd_pending_clr got=%b exp=0", pending); end
      advance();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_high got=%b exp=1", cmd_ready); end
      total++; if (commit !== 1'b0) begin bad++; $display("FAIL cmd_commit_one got=%b exp=0", commit); end
   endtask

   task automatic test_anim();
      int exp_ax[5];
      exp_ax = '{320, 320, 321, 321, 322};
      hw_reset();
      anim_en = 1'b1;
      total++; if (ax !== 10'(exp_ax[0])) begin bad++; $display("FAIL anim_ax0 got=%0d exp=%0d", ax, exp_ax[0]); end
      for (int k = 1; k < 5; k++) begin
         run_to_commit();
         total++; if (ax !== 10'(exp_ax[k])) begin bad++; $display("FAIL anim_ax%0d got=%0d exp=%0d", k, ax, exp_ax[k]); end
         total++; if (dvec !== mvec()) begin bad++; $display("FAIL anim_vtx%0d got=%h exp=%h", k, dvec, mvec()); end
      end
   endtask

   task automatic test_bounce();
      int exp_seq[6][3];
      hw_reset();
      anim_en = 1'b1;
      send_cmd(100, 5, 200, 6, 639, 7);
      run_to_commit();
      total++; if (cx !== 10'd639) begin bad++; $display("FAIL bounce_load got=%0d exp=639", cx); end
      run_to_commit(); run_to_commit();
      total++; if ({ax, bx, cx} !== {10'd99, 10'd199, 10'd638}) begin bad++; $display("FAIL bounce_right got=%0d/%0d/%0d exp=99/199/638", ax, bx, cx); end
      run_to_commit(); run_to_commit();
      total++; if (cx !== 10'd637) begin bad++; $display("FAIL bounce_left_dir got=%0d exp=637", cx); end
      // Narrow gap on both sides: reverse right, then reverse at the left edge.
      send_cmd(1, 0, 2, 0, 639, 0);
      exp_seq = '{'{1, 2, 639}, '{1, 2, 639}, '{0, 1, 638}, '{0, 1, 638}, '{1, 2, 639}, '{1, 2, 639}};
      for (int k = 0; k < 6; k++) begin
         run_to_commit();
         total++;
         if ({ax, bx, cx} !== {10'(exp_seq[k][0]), 10'(exp_seq[k][1]), 10'(exp_seq[k][2])}) begin
            bad++;
            $display("FAIL bounce_edge%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, ax, bx, cx,
                     exp_seq[k][0], exp_seq[k][1], exp_seq[k][2]);
         end
      end
      send_cmd(5, 1, 0, 2, 9, 3);
      run_to_commit(); run_to_commit(); run_to_commit();
      total++; if (bx !== 10'd1) begin bad++; $display("FAIL bounce_bx0 got=%0d exp=1", bx); end
   endtask

   task automatic test_commit_cycle_cmd();
      logic [59:0] exp_v;
      exp_v = {10'd7, 10'd8, 10'd9, 10'd10, 10'd11, 10'd12};
      hw_reset();
      anim_en = 1'b1;
      run_to_commit(); run_to_commit();
      total++; if (ax !== 10'd321) begin bad++; $display("FAIL cc_step got=%0d exp=321", ax); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cc_ready got=%b exp=1", cmd_ready); end
      send_cmd(7, 8, 9, 10, 11, 12);
      total++; if (pending !== 1'b1) begin bad++; $display("FAIL cc_pending got=%b exp=1", pending); end
      total++; if (ax !== 10'd321) begin bad++; $display("FAIL cc_hold got=%0d exp=321", ax); end
      run_to_commit();
      total++; if (dvec !== exp_v) begin bad++; $display("FAIL cc_applied got=%h exp=%h", dvec, exp_v); end
   endtask

   task automatic test_reset_midframe();
      anim_en = 1'b0;
      while (ry != 2) advance();
      send_cmd(1, 2, 3, 4, 5, 6);
      advance();
      total++; if (pending !== 1'b1) begin bad++; $display("FAIL mid_pending_pre got=%b exp=1", pending); end
      resetn = 1'b0;
      #1;
      model_reset();
      total++; if (dvec !== DEF_VEC) begin bad++; $display("FAIL mid_vtx got=%h exp=%h", dvec, DEF_VEC); end
      total++; if (pending !== 1'b0) begin bad++; $display("FAIL mid_pending got=%b exp=0", pending); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", cmd_ready); end
      @(posedge clk_pix); #1;
      resetn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         run_to_commit();
         total++; if (dvec !== DEF_VEC) begin bad++; $display("FAIL mid_lost%0d got=%h exp=%h", k, dvec, DEF_VEC); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99, 0) == 0) anim_en = ~anim_en;
         if (cmd_valid) begin
            if ($urandom_range(1, 0) == 0) cmd_valid = 1'b0;
         end else if ($urandom_range(24, 0) == 0) begin
            cmd_valid = 1'b1;
            cmd_ax = 10'($urandom_range(638, 1)); cmd_ay = 10'($urandom_range(1023, 0));
            cmd_bx = 10'($urandom_range(638, 1)); cmd_by = 10'($urandom_range(1023, 0));
            cmd_cx = 10'($urandom_range(638, 1)); cmd_cy = 10'($urandom_range(1023, 0));
         end
         advance();
         total++; if (commit !== m_commit) begin bad++; $display("FAIL rand_commit cyc=%0d got=%b exp=%b", i, commit, m_commit); end
         total++; if (dvec !== mvec()) begin bad++; $display("FAIL rand_vtx cyc=%0d got=%h exp=%h", i, dvec, mvec()); end
         total++; if (pending !== m_pend) begin bad++; $display("FAIL rand_pending cyc=%0d got=%b exp=%b", i, pending, m_pend); end
         total++; if (cmd_ready !== !m_pend) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, cmd_ready, !m_pend); end
      end
      cmd_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle_frames();
      test_command();
      test_anim();
      test_bounce();
      test_commit_cycle_cmd();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
